// File: rtl/usb_rx_packet.sv
// Receive-side packet decoder: PID/CRC validation, token and handshake decode, CRC-stripped payload stream.
// Optional feature macro: USB_RX_ERRCNT_EN adds a saturating err_count output.
module usb_rx_packet #(
    parameter int unsigned MAX_PAYLOAD = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        usb_reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic [3:0]  pid,
    output logic        token_valid,
    output logic [6:0]  token_addr,
    output logic [3:0]  token_endp,
    output logic [10:0] frame_num,
    output logic        handshake_valid,
    output logic [7:0]  data_out,
    output logic        data_out_valid,
    output logic        data_done,
    output logic        data_ok,
    output logic [9:0]  data_len,
    output logic        pkt_error
`ifdef USB_RX_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [10:0] OVER_AT = 11'(MAX_PAYLOAD + 2);
    localparam logic [9:0]  MAX_LEN = 10'(MAX_PAYLOAD);
    localparam logic [3:0]  PID_SOF = 4'h5;

    typedef enum logic [2:0] {
        S_WAIT_END,
        S_IDLE,
        S_TOKEN,
        S_DATA,
        S_HSK
    } state_e;

    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        logic       fb;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = r[4] ^ d[i];
            r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    state_e      state_q;
    logic        rst;
    logic        err_q;
    logic        is_data_q;
    logic [3:0]  pid_rx_q;
    logic [10:0] cnt_q;
    logic [9:0]  out_cnt_q;
    logic [4:0]  crc5_q;
    logic [15:0] crc16_q;
    logic [7:0]  dly0_q;
    logic [7:0]  dly1_q;

    logic [3:0]  pid_q;
    logic        token_valid_q;
    logic [6:0]  token_addr_q;
    logic [3:0]  token_endp_q;
    logic [10:0] frame_num_q;
    logic        handshake_valid_q;
    logic [7:0]  data_out_q;
    logic        data_out_valid_q;
    logic        data_done_q;
    logic        data_ok_q;
    logic [9:0]  data_len_q;
    logic        pkt_error_q;

    // Byte-stage values: the current byte (if any) folded in, so EOP in the same cycle sees it.
    logic [4:0]  crc5_d;
    logic [15:0] crc16_d;
    logic [7:0]  d0_d;
    logic [7:0]  d1_d;
    logic [10:0] cnt_d;
    logic [9:0]  out_cnt_d;
    logic        emit_d;
    logic        bad_d;
    logic        data_good_d;
    logic        pid_good;

    assign rst = reset | usb_reset;

    always_comb begin
        crc5_d  = crc5_q;
        crc16_d = crc16_q;
        d0_d    = dly0_q;
        d1_d    = dly1_q;
        if (rx_valid) begin
            crc5_d  = crc5_byte(crc5_q, rx_data);
            crc16_d = crc16_byte(crc16_q, rx_data);
            d0_d    = rx_data;
            d1_d    = dly0_q;
        end
        cnt_d       = cnt_q + {10'd0, rx_valid};
        emit_d      = (state_q == S_DATA) && rx_valid && (cnt_q >= 11'd2) && (out_cnt_q < MAX_LEN);
        out_cnt_d   = out_cnt_q + {9'd0, emit_d};
        bad_d       = rx_error ||
                      (rx_valid && (((state_q == S_TOKEN) && (cnt_q >= 11'd2)) ||
                                    (state_q == S_HSK) ||
                                    ((state_q == S_DATA) && (cnt_q >= OVER_AT))));
        data_good_d = (cnt_d >= 11'd2) && (crc16_d == 16'h800D);
        pid_good    = (rx_data[7:4] == ~rx_data[3:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_WAIT_END;
            err_q             <= 1'b0;
            is_data_q         <= 1'b0;
            pid_rx_q          <= '0;
            cnt_q             <= '0;
            out_cnt_q         <= '0;
            crc5_q            <= '1;
            crc16_q           <= '1;
            dly0_q            <= '0;
            dly1_q            <= '0;
            pid_q             <= '0;
            token_valid_q     <= 1'b0;
            token_addr_q      <= '0;
            token_endp_q      <= '0;
            frame_num_q       <= '0;
            handshake_valid_q <= 1'b0;
            data_out_q        <= '0;
            data_out_valid_q  <= 1'b0;
            data_done_q       <= 1'b0;
            data_ok_q         <= 1'b0;
            data_len_q        <= '0;
            pkt_error_q       <= 1'b0;
        end else begin
            token_valid_q     <= 1'b0;
            handshake_valid_q <= 1'b0;
            data_out_valid_q  <= 1'b0;
            data_done_q       <= 1'b0;
            pkt_error_q       <= 1'b0;

            unique case (state_q)
                S_WAIT_END: begin
                    if (!rx_active) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b0;
                        if (err_q) begin
                            pkt_error_q <= 1'b1;
                            if (is_data_q) begin
                                data_done_q <= 1'b1;
                                data_ok_q   <= 1'b0;
                                data_len_q  <= out_cnt_q;
                            end
                        end
                    end
                end

                S_IDLE: begin
                    if (rx_valid) begin
                        pid_rx_q  <= rx_data[3:0];
                        is_data_q <= pid_good && (rx_data[1:0] == 2'b11);
                        err_q     <= 1'b0;
                        cnt_q     <= '0;
                        out_cnt_q <= '0;
                        crc5_q    <= '1;
                        crc16_q   <= '1;
                        if (!pid_good) begin
                            if (rx_active) begin
                                state_q <= S_WAIT_END;
                                err_q   <= 1'b1;
                            end else begin
                                pkt_error_q <= 1'b1;
                            end
                        end else if (!rx_active) begin
                            // Single-byte packet: only a handshake is complete on its own.
                            unique case (rx_data[1:0])
                                2'b10: begin
                                    handshake_valid_q <= 1'b1;
                                    pid_q             <= rx_data[3:0];
                                end
                                2'b01: pkt_error_q <= 1'b1;
                                2'b11: begin
                                    pkt_error_q <= 1'b1;
                                    data_done_q <= 1'b1;
                                    data_ok_q   <= 1'b0;
                                    data_len_q  <= '0;
                                end
                                default: ;
                            endcase
                        end else begin
                            unique case (rx_data[1:0])
                                2'b01:   state_q <= S_TOKEN;
                                2'b11:   state_q <= S_DATA;
                                2'b10:   state_q <= S_HSK;
                                default: state_q <= S_WAIT_END;
                            endcase
                        end
                    end
                end

                default: begin
                    if (bad_d) begin
                        if (rx_active) begin
                            state_q <= S_WAIT_END;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= S_IDLE;
                            pkt_error_q <= 1'b1;
                            if (is_data_q) begin
                                data_done_q <= 1'b1;
                                data_ok_q   <= 1'b0;
                                data_len_q  <= out_cnt_q;
                            end
                        end
                    end else begin
                        cnt_q     <= cnt_d;
                        crc5_q    <= crc5_d;
                        crc16_q   <= crc16_d;
                        dly0_q    <= d0_d;
                        dly1_q    <= d1_d;
                        out_cnt_q <= out_cnt_d;
                        if (emit_d) begin
                            data_out_q       <= dly1_q;
                            data_out_valid_q <= 1'b1;
                        end
                        if (!rx_active) begin
                            state_q <= S_IDLE;
                            if (state_q == S_TOKEN) begin
                                if ((cnt_d == 11'd2) && (crc5_d == 5'b01100)) begin
                                    token_valid_q <= 1'b1;
                                    pid_q         <= pid_rx_q;
                                    if (pid_rx_q == PID_SOF) begin
                                        frame_num_q <= {d0_d[2:0], d1_d};
                                    end else begin
                                        token_addr_q <= d1_d[6:0];
                                        token_endp_q <= {d0_d[2:0], d1_d[7]};
                                    end
                                end else begin
                                    pkt_error_q <= 1'b1;
                                end
                            end else if (state_q == S_DATA) begin
                                data_done_q <= 1'b1;
                                data_ok_q   <= data_good_d;
                                data_len_q  <= out_cnt_d;
                                pkt_error_q <= !data_good_d;
                                if (data_good_d) begin
                                    pid_q <= pid_rx_q;
                                end
                            end else begin
                                handshake_valid_q <= 1'b1;
                                pid_q             <= pid_rx_q;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign pid             = pid_q;
    assign token_valid     = token_valid_q;
    assign token_addr      = token_addr_q;
    assign token_endp      = token_endp_q;
    assign frame_num       = frame_num_q;
    assign handshake_valid = handshake_valid_q;
    assign data_out        = data_out_q;
    assign data_out_valid  = data_out_valid_q;
    assign data_done       = data_done_q;
    assign data_ok         = data_ok_q;
    assign data_len        = data_len_q;
    assign pkt_error       = pkt_error_q;

`ifdef USB_RX_ERRCNT_EN
    // Survives usb_reset so bus resets do not hide the error history.
    logic [7:0] err_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else if (pkt_error_q && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule
